// File: rtl/bure_imem_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory.
// Optional trailing checksum word enabled by defining BURE_LOADER_CHECKSUM_EN.
module bure_imem_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 1024
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_load_start,
    input  logic [$clog2(MAX_WORDS):0]   i_load_words,
    input  logic                         i_byte_valid,
    input  logic [7:0]                   i_byte,
    output logic                         o_byte_ready,
    output logic                         o_mem_wen,
    output logic                         o_mem_wdata_valid,
    output logic [ADDR_WIDTH-1:0]        o_mem_waddr,
    output logic [DATA_WIDTH-1:0]        o_mem_wdata,
    output logic                         o_core_hold,
    output logic [ADDR_WIDTH-1:0]        o_new_pc,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_error
);

    localparam int               LEN_W   = $clog2(MAX_WORDS) + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3
`ifdef BURE_LOADER_CHECKSUM_EN
        , S_CHK = 3'd4
`endif
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_word;
    logic [1:0]              r_byte_idx;
    logic                    w_byte_fire;
    logic [LEN_W-1:0]        w_len_clamped;
    logic [LEN_W-1:0]        w_cnt_inc;
    logic                    w_last_byte;
    logic [3:0]              w_lane_we;
    state_t                  w_end_state;
`ifdef BURE_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   r_sum;
    logic                    r_error;
`endif

    assign w_len_clamped = (i_load_words > MAX_LEN) ? MAX_LEN : i_load_words;
    assign w_cnt_inc     = r_cnt + LEN_W'(1);
    assign w_byte_fire   = i_byte_valid && o_byte_ready;
    assign w_last_byte   = w_byte_fire && (r_byte_idx == 2'd3);

    // After the data words either the checksum word follows or the load ends.
`ifdef BURE_LOADER_CHECKSUM_EN
    assign w_end_state = S_CHK;
`else
    assign w_end_state = S_DONE;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_load_start) begin
                    w_state_next = (w_len_clamped == '0) ? w_end_state : S_RECV;
                end
            end
            S_RECV: begin
                if (w_last_byte) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_next = (w_cnt_inc < r_len) ? S_RECV : w_end_state;
            end
`ifdef BURE_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_last_byte) begin
                    w_state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_byte_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_byte_fire) begin
                r_byte_idx <= r_byte_idx + 2'd1;
            end
            if (r_state == S_IDLE && i_load_start) begin
                r_len      <= w_len_clamped;
                r_addr     <= BASE_ADDR;
                r_cnt      <= '0;
                r_byte_idx <= '0;
            end
            if (r_state == S_WRITE) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
                r_cnt  <= w_cnt_inc;
            end
        end
    end

    // One register lane per byte position; byte k of a word fills bits [8k+7:8k].
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_lane_we[gi] = w_byte_fire && (r_byte_idx == 2'(gi));

        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                r_word[8*gi +: 8] <= '0;
            end else if (w_lane_we[gi]) begin
                r_word[8*gi +: 8] <= i_byte;
            end
        end
    end

`ifdef BURE_LOADER_CHECKSUM_EN
    // The checksum word is left in r_word by CHK; it is compared on the DONE cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sum   <= '0;
            r_error <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_load_start) begin
                r_sum   <= '0;
                r_error <= 1'b0;
            end
            if (r_state == S_WRITE) begin
                r_sum <= r_sum + r_word;
            end
            if (r_state == S_DONE) begin
                r_error <= (r_word != r_sum);
            end
        end
    end
    assign o_error = r_error;
`else
    assign o_error = 1'b0;
`endif

`ifdef BURE_LOADER_CHECKSUM_EN
    assign o_byte_ready = (r_state == S_RECV) || (r_state == S_CHK);
`else
    assign o_byte_ready = (r_state == S_RECV);
`endif

    assign o_mem_wen         = (r_state == S_WRITE);
    assign o_mem_wdata_valid = o_mem_wen;
    assign o_mem_waddr       = r_addr;
    assign o_mem_wdata       = r_word;
    assign o_busy            = (r_state != S_IDLE);
    assign o_core_hold       = o_busy;
    assign o_done            = (r_state == S_DONE);
    assign o_new_pc          = BASE_ADDR;

endmodule

// File: tb/tb_bure_imem_loader.sv
// Directed bench for bure_imem_loader; also exercises the checksum path when BURE_LOADER_CHECKSUM_EN is defined.
module tb_bure_imem_loader;

    localparam int MAXW = 1024;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_load_start = 1'b0;
    logic [10:0] i_load_words = '0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte = '0;
    logic        o_byte_ready, o_mem_wen, o_mem_wdata_valid;
    logic [31:0] o_mem_waddr, o_mem_wdata, o_new_pc;
    logic        o_core_hold, o_busy, o_done, o_error;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_n     = 0;
    int vld_bad  = 0;
    logic [31:0] wr_addr [0:2047];
    logic [31:0] wr_data [0:2047];

    bure_imem_loader dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_load_start(i_load_start),
        .i_load_words(i_load_words), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
        .o_byte_ready(o_byte_ready), .o_mem_wen(o_mem_wen),
        .o_mem_wdata_valid(o_mem_wdata_valid), .o_mem_waddr(o_mem_waddr),
        .o_mem_wdata(o_mem_wdata), .o_core_hold(o_core_hold), .o_new_pc(o_new_pc),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_mem_wen != o_mem_wdata_valid) vld_bad++;
        if (o_mem_wen && wr_n < 2048) begin
            wr_addr[wr_n] = o_mem_waddr;
            wr_data[wr_n] = o_mem_wdata;
            wr_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Caller sits at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        if (gap) @(negedge i_clk);
        while (!o_byte_ready && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 100) check("ready_timeout", 32'(o_byte_ready), 32'd1);
        i_byte_valid = 1'b1;
        i_byte       = b;
        @(negedge i_clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic send_csum(input logic [31:0] s);
`ifdef BURE_LOADER_CHECKSUM_EN
        send_word(s, 1'b0);
`else
        if (s === 32'hxxxx_xxxx) $display("unused checksum");
`endif
    endtask

    task automatic start(input int n);
        @(negedge i_clk);
        i_load_start = 1'b1;
        i_load_words = 11'(n);
        @(negedge i_clk);
        i_load_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!o_done && t < 200) begin
            @(negedge i_clk);
            t++;
        end
        check({tag, "_done"}, 32'(o_done), 32'd1);
        check({tag, "_hold_in_done"}, 32'(o_core_hold), 32'd1);
        @(negedge i_clk);
        check({tag, "_done_1cyc"}, 32'(o_done), 32'd0);
        check({tag, "_hold_drop"}, 32'(o_core_hold), 32'd0);
    endtask

    initial begin
        int base;
        logic [31:0] sum;

        // T1: reset state
        repeat (3) @(negedge i_clk);
        check("rst_ready", 32'(o_byte_ready), 32'd0);
        check("rst_wen",   32'(o_mem_wen), 32'd0);
        check("rst_wvld",  32'(o_mem_wdata_valid), 32'd0);
        check("rst_waddr", o_mem_waddr, 32'd0);
        check("rst_wdata", o_mem_wdata, 32'd0);
        check("rst_hold",  32'(o_core_hold), 32'd0);
        check("rst_pc",    o_new_pc, 32'd0);
        check("rst_busy",  32'(o_busy), 32'd0);
        check("rst_done",  32'(o_done), 32'd0);
        check("rst_err",   32'(o_error), 32'd0);
        i_rstn = 1'b1;

        // T2: basic two-word load
        base = wr_n;
        start(2);
        check("t2_busy",  32'(o_busy), 32'd1);
        check("t2_hold",  32'(o_core_hold), 32'd1);
        check("t2_ready", 32'(o_byte_ready), 32'd1);
        send_word(32'h0000_0114, 1'b0);
        check("t2_lat_wen",   32'(o_mem_wen), 32'd1);
        check("t2_lat_waddr", o_mem_waddr, 32'd0);
        check("t2_lat_wdata", o_mem_wdata, 32'h0000_0114);
        send_word(32'h0000_0214, 1'b0);
        send_csum(32'h0000_0328);
        wait_done("t2");
        check("t2_busy_end", 32'(o_busy), 32'd0);
        check("t2_nwr",   32'(wr_n - base), 32'd2);
        check("t2_addr0", wr_addr[base], 32'd0);
        check("t2_data0", wr_data[base], 32'h0000_0114);
        check("t2_addr1", wr_addr[base+1], 32'd1);
        check("t2_data1", wr_data[base+1], 32'h0000_0214);

        // T3: backpressure
        base = wr_n;
        start(2);
        send_word(32'h0000_0114, 1'b1);
        send_word(32'h0000_0214, 1'b1);
        send_csum(32'h0000_0328);
        wait_done("t3");
        check("t3_nwr",   32'(wr_n - base), 32'd2);
        check("t3_data0", wr_data[base], 32'h0000_0114);
        check("t3_addr1", wr_addr[base+1], 32'd1);
        check("t3_data1", wr_data[base+1], 32'h0000_0214);

        // T4: reset in mid-load
        base = wr_n;
        start(2);
        send_word(32'h0000_0114, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'h02, 1'b0);
        i_rstn = 1'b0;
        repeat (2) @(negedge i_clk);
        check("t4_busy_rst",  32'(o_busy), 32'd0);
        check("t4_ready_rst", 32'(o_byte_ready), 32'd0);
        i_rstn = 1'b1;
        repeat (2) @(negedge i_clk);
        check("t4_nwr_abort", 32'(wr_n - base), 32'd1);
        check("t4_idle",      32'(o_busy), 32'd0);
        base = wr_n;
        start(1);
        send_word(32'hAAAA_AAAA, 1'b0);
        send_csum(32'hAAAA_AAAA);
        wait_done("t4");
        check("t4_nwr",  32'(wr_n - base), 32'd1);
        check("t4_addr", wr_addr[base], 32'd0);
        check("t4_data", wr_data[base], 32'hAAAA_AAAA);

        // T5a: zero-length load
        base = wr_n;
        start(0);
`ifdef BURE_LOADER_CHECKSUM_EN
        send_csum(32'd0);
        wait_done("t5a");
        check("t5a_err", 32'(o_error), 32'd0);
`else
        check("t5a_done_next", 32'(o_done), 32'd1);
        @(negedge i_clk);
        check("t5a_busy_end", 32'(o_busy), 32'd0);
`endif
        check("t5a_nwr", 32'(wr_n - base), 32'd0);

        // T5b: start while busy is ignored
        base = wr_n;
        start(1);
        i_load_start = 1'b1;
        i_load_words = 11'd3;
        send_word(32'h1234_5678, 1'b0);
        i_load_start = 1'b0;
        send_csum(32'h1234_5678);
        wait_done("t5b");
        check("t5b_nwr",  32'(wr_n - base), 32'd1);
        check("t5b_data", wr_data[base], 32'h1234_5678);
        check("t5b_idle", 32'(o_busy), 32'd0);

        // T5c: length clamped to MAX_WORDS
        base = wr_n;
        sum  = '0;
        start(MAXW + 5);
        for (int i = 0; i < MAXW; i++) begin
            send_word(32'(i), 1'b0);
            sum = sum + 32'(i);
        end
        send_csum(sum);
        wait_done("t5c");
        check("t5c_nwr",   32'(wr_n - base), 32'(MAXW));
        check("t5c_laddr", wr_addr[base+MAXW-1], 32'(MAXW-1));
        check("t5c_ldata", wr_data[base+MAXW-1], 32'(MAXW-1));

`ifdef BURE_LOADER_CHECKSUM_EN
        // T6: checksum good, then bad, then cleared by a new start
        start(2);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd3, 1'b0);
        wait_done("t6a");
        check("t6a_err", 32'(o_error), 32'd0);
        start(2);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd4, 1'b0);
        wait_done("t6b");
        check("t6b_err", 32'(o_error), 32'd1);
        repeat (3) @(negedge i_clk);
        check("t6b_sticky", 32'(o_error), 32'd1);
        start(0);
        check("t6c_clear", 32'(o_error), 32'd0);
        send_word(32'd0, 1'b0);
        wait_done("t6c");
        check("t6c_err", 32'(o_error), 32'd0);
`endif

        check("wdata_valid_eq_wen", 32'(vld_bad), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
